// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: datapath width, boot address and the
// fetch controller state encoding.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: circular FIFO with a combinational head so the fetch unit
// can present the oldest entry with zero latency; flush beats push and pop.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [WIDTH-1:0]         o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == (AW+1)'(0));
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Storage, pointers and occupancy; flush discards everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction prefetcher: one outstanding request at a time, results tagged
// with their address in a small FIFO and matched against the core's PC.
module instr_fetch_unit #(
  parameter int                XLEN     = riscv_pkg::XLEN,
  parameter int                DEPTH    = 4,
  parameter logic [XLEN-1:0]   RESET_PC = riscv_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   PC,
  input  logic              Advance,
  input  logic              Redirect,
  output logic [XLEN-1:0]   Instr,
  output logic              InstrValid,
  output logic              Stall,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [XLEN-1:0]   imem_rdata
);

  import riscv_pkg::*;

  localparam int              CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

  fetch_state_t      r_state;
  logic [XLEN-1:0]   r_fetch_addr;
  logic [XLEN-1:0]   r_req_addr;
  logic              r_imem_req;

  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;
  logic [2*XLEN-1:0] w_head;
  logic [XLEN-1:0]   w_head_addr;
  logic [XLEN-1:0]   w_head_data;
  logic              w_head_hit;
  logic              w_flush;
  logic              w_push;
  logic              w_pop;

  assign w_head_addr = w_head[2*XLEN-1:XLEN];
  assign w_head_data = w_head[XLEN-1:0];
  assign w_head_hit  = ~w_empty & (w_head_addr == PC);
  // A stale head (addr != PC) is treated exactly like an explicit redirect.
  assign w_flush     = Redirect | (~w_empty & ~(w_head_addr == PC));
  assign InstrValid  = w_head_hit & ~Redirect;
  assign Instr       = InstrValid ? w_head_data : '0;
  assign Stall       = ~InstrValid;
  assign w_pop       = Advance & InstrValid;
  assign w_push      = (r_state == WAIT) & imem_rvalid & ~w_flush & ~w_full;
  assign imem_req    = r_imem_req;
  assign imem_addr   = r_fetch_addr;

  fetch_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_data  ({r_req_addr, imem_rdata}),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_head  (w_head)
  );

  // Fetch controller: request issue, response tracking and flush recovery.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_fetch_addr <= RESET_PC;
      r_req_addr   <= RESET_PC;
      r_imem_req   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_flush) begin
            r_fetch_addr <= PC;
          end else if (w_count < DEPTH_C) begin
            r_state    <= REQ;
            r_imem_req <= 1'b1;
          end
        end
        REQ: begin
          if (imem_gnt) begin
            r_req_addr <= r_fetch_addr;
            r_imem_req <= 1'b0;
            if (w_flush) begin
              r_fetch_addr <= PC;
              r_state      <= DISCARD;
            end else begin
              r_fetch_addr <= r_fetch_addr + XLEN'(4);
              r_state      <= WAIT;
            end
          end else if (w_flush) begin
            r_fetch_addr <= PC;
            r_imem_req   <= 1'b0;
            r_state      <= IDLE;
          end
        end
        WAIT: begin
          if (w_flush) begin
            r_fetch_addr <= PC;
            r_state      <= imem_rvalid ? IDLE : DISCARD;
          end else if (imem_rvalid) begin
            r_state <= IDLE;
          end
        end
        DISCARD: begin
          if (w_flush) begin
            r_fetch_addr <= PC;
          end
          if (imem_rvalid) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: a queue-based model of the prefetch
// buffer plus a behavioural memory and core drive the DUT and judge it.
module tb_instr_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] PC = 32'd0;
  logic        Advance = 1'b0;
  logic        Redirect = 1'b0;
  logic [31:0] Instr;
  logic        InstrValid;
  logic        Stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .XLEN     (32),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .PC          (PC),
    .Advance     (Advance),
    .Redirect    (Redirect),
    .Instr       (Instr),
    .InstrValid  (InstrValid),
    .Stall       (Stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] q[$];
  logic [31:0] gnt_log[$];
  logic [31:0] next_addr;
  logic [31:0] m_addr;
  logic [31:0] redir_pc;
  logic [31:0] prev_addr;
  bit  m_pending, m_poison, redir_now, pc_adv, prev_stall;
  int  m_delay, m_gnt_delay, rv_min, rv_max, gnt_max;
  int  adv_pct, redir_pct, jump_pct;
  int  cyc, first_valid, n_pop, n_req_wait;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(9) == 0)
      return 32'hFFFF_FFF4 + 32'd4 * 32'($urandom_range(2));
    return 32'h0000_1000 + 32'd4 * 32'($urandom_range(63));
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_req"},   32'(imem_req),   32'd0);
    check_val({tag, "_addr"},  imem_addr,       32'h0000_0000);
    check_val({tag, "_valid"}, 32'(InstrValid), 32'd0);
    check_val({tag, "_instr"}, Instr,           32'd0);
    check_val({tag, "_stall"}, 32'(Stall),      32'd1);
  endtask

  task automatic model_reset(input bit keep_stale);
    q.delete();
    gnt_log.delete();
    next_addr   = 32'h0000_0000;
    pc_adv      = 1'b0;
    prev_stall  = 1'b0;
    redir_now   = 1'b0;
    cyc         = 0;
    first_valid = -1;
    n_pop       = 0;
    n_req_wait  = 0;
    m_gnt_delay = 0;
    if (keep_stale) begin
      m_poison = 1'b1;
      m_delay  = 0;
    end else begin
      m_pending = 1'b0;
      m_poison  = 1'b0;
    end
  endtask

  // Holds reset for one clock, checks reset outputs, releases on a negedge.
  task automatic do_reset(input logic [31:0] pc0);
    reset = 1'b0; PC = pc0; Advance = 1'b0; Redirect = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    #2;
    check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b1;
    model_reset(1'b0);
  endtask

  // One clock: drive core and memory, compare against the model, advance it.
  task automatic step();
    bit valid_m, flush_m, pop_m, push_m;
    logic [31:0] push_addr;
    if (pc_adv) PC = PC + 32'd4;
    pc_adv   = 1'b0;
    Redirect = 1'b0;
    if (redir_now) begin
      Redirect = 1'b1; PC = redir_pc; redir_now = 1'b0;
    end else if (int'($urandom_range(99)) < redir_pct) begin
      Redirect = 1'b1; PC = rand_pc();
    end else if (int'($urandom_range(99)) < jump_pct) begin
      PC = rand_pc();
    end
    Advance = (int'($urandom_range(99)) < adv_pct);
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    if (m_pending) begin
      if (m_delay == 0) begin
        imem_rvalid = 1'b1; imem_rdata = mem_word(m_addr);
      end else m_delay--;
    end else if (imem_req) begin
      if (m_gnt_delay == 0) imem_gnt = 1'b1;
      else m_gnt_delay--;
    end
    #2;
    valid_m = (q.size() != 0) && (q[0] == PC) && !Redirect;
    flush_m = Redirect || ((q.size() != 0) && (q[0] != PC));
    check_val("instr_valid", 32'(InstrValid), 32'(valid_m));
    check_val("instr", Instr, valid_m ? mem_word(PC) : 32'd0);
    check_val("stall", 32'(Stall), 32'(!valid_m));
    if (imem_req) begin
      check_val("req_addr", imem_addr, next_addr);
      check_val("req_room", 32'(q.size() < DEPTH), 32'd1);
    end
    if (m_pending) check_val("one_outstanding", 32'(imem_req), 32'd0);
    if (prev_stall) begin
      check_val("req_held", 32'(imem_req), 32'd1);
      check_val("addr_stable", imem_addr, prev_addr);
    end
    if (InstrValid && first_valid < 0) first_valid = cyc;
    if (imem_req && !imem_gnt) n_req_wait++;
    pop_m     = Advance && valid_m;
    push_m    = 1'b0;
    push_addr = m_addr;
    if (imem_rvalid && m_pending) begin
      push_m    = !(m_poison || flush_m);
      m_pending = 1'b0;
    end
    if (imem_req && imem_gnt) begin
      gnt_log.push_back(imem_addr);
      m_pending   = 1'b1;
      m_addr      = imem_addr;
      m_poison    = flush_m;
      m_delay     = int'($urandom_range(rv_max, rv_min));
      m_gnt_delay = int'($urandom_range(gnt_max, 0));
    end else if (m_pending && flush_m) begin
      m_poison = 1'b1;
    end
    if (flush_m) next_addr = PC;
    else if (imem_req && imem_gnt) next_addr = next_addr + 32'd4;
    if (flush_m) q.delete();
    else begin
      if (pop_m) void'(q.pop_front());
      if (push_m) q.push_back(push_addr);
    end
    if (pop_m) n_pop++;
    pc_adv     = pop_m;
    prev_stall = imem_req && !imem_gnt && !flush_m;
    prev_addr  = imem_addr;
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_mode(input int adv, input int redir, input int jump,
                          input int gmax, input int rmin, input int rmax);
    adv_pct = adv; redir_pct = redir; jump_pct = jump;
    gnt_max = gmax; rv_min = rmin; rv_max = rmax;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_pending = 1'b0;
    m_addr    = 32'd0;
    @(negedge clk);

    // Streaming with 1-cycle memory: first hit at cycle 3, addresses 0,4,8,12.
    set_mode(100, 0, 0, 0, 0, 0);
    do_reset(32'h0000_0000);
    repeat (13) step();
    check_val("lat_first_valid", 32'(first_valid), 32'd3);
    check_val("lat_pops", 32'(n_pop), 32'd4);
    check_val("seq_ngnt", 32'(gnt_log.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++)
      if (i < gnt_log.size()) check_val("seq_addr", gnt_log[i], 32'(4 * i));

    // No consumption: exactly DEPTH requests, then silence until a pop.
    set_mode(0, 0, 0, 0, 0, 0);
    do_reset(32'h0000_0000);
    repeat (20) step();
    check_val("fill_ngnt", 32'(gnt_log.size()), 32'(DEPTH));
    check_val("fill_req_idle", 32'(imem_req), 32'd0);
    adv_pct = 100;
    repeat (6) step();
    check_val("fill_resume", 32'(gnt_log.size() >= DEPTH + 1), 32'd1);

    // Redirect while waiting for data: returning word dropped, refetch 0x100.
    set_mode(100, 0, 0, 0, 2, 2);
    do_reset(32'h0000_0000);
    repeat (2) step();
    redir_now = 1'b1; redir_pc = 32'h0000_0100;
    repeat (12) step();
    check_val("redir_ngnt", 32'(gnt_log.size() >= 2), 32'd1);
    if (gnt_log.size() >= 2) check_val("redir_addr", gnt_log[1], 32'h0000_0100);
    check_val("redir_first_valid", 32'(first_valid), 32'd10);

    // Grant held off five cycles: request and address must stay put.
    set_mode(100, 0, 0, 0, 0, 0);
    do_reset(32'h0000_0000);
    m_gnt_delay = 5;
    repeat (10) step();
    check_val("gnt_wait", 32'(n_req_wait), 32'd5);
    check_val("gnt_first_valid", 32'(first_valid), 32'd8);

    // Address wrap from the top of the space.
    set_mode(100, 0, 0, 0, 0, 0);
    do_reset(32'h0000_0000);
    redir_now = 1'b1; redir_pc = 32'hFFFF_FFFC;
    repeat (12) step();
    check_val("wrap_ngnt", 32'(gnt_log.size() >= 2), 32'd1);
    if (gnt_log.size() >= 2) begin
      check_val("wrap_addr0", gnt_log[0], 32'hFFFF_FFFC);
      check_val("wrap_addr1", gnt_log[1], 32'h0000_0000);
    end

    // Asynchronous reset while a request is in flight; late data is ignored.
    set_mode(100, 0, 0, 0, 3, 3);
    do_reset(32'h0000_0000);
    repeat (2) step();
    check_val("arst_granted", 32'(gnt_log.size()), 32'd1);
    #1 reset = 1'b0;
    #1 check_reset_outputs("arst");
    @(negedge clk);
    reset = 1'b1;
    model_reset(1'b1);
    PC = m_addr;
    set_mode(100, 0, 0, 0, 0, 0);
    repeat (8) step();
    check_val("arst_first_valid", 32'(first_valid), 32'd3);

    // Randomized traffic: redirects, silent jumps, variable memory latency.
    set_mode(60, 4, 2, 3, 0, 3);
    do_reset(32'h0000_1000);
    repeat (4000) step();
    check_val("rand_progress", 32'(n_pop > 50), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
